// File: rtl/comparator_chk_pkg.sv
// Shared types and constants for the comparator self-check sequencer.
// The CMP_CHK_FAIL_CAPTURE_EN build option is handled in comparator_checker.
package comparator_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 4;
  localparam int ERR_W       = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

  // Reference behaviour of the 1-bit equality comparator under test.
  function automatic logic expected_z(input logic x, input logic y);
    return ~(x ^ y);
  endfunction

endpackage

// File: rtl/comparator_checker_hold_timer.sv
// Hold-period timer: counts enabled cycles and pulses expire on the final
// cycle of each HOLD_CYCLES-long window, then restarts from zero.
module hold_timer #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = en && (cnt_q == LAST);

  // Next count: clear wins, wrap on expiry, otherwise count while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/comparator_checker.sv
// Drives all (x,y) pairs onto a 1-bit equality comparator and checks z.
// Define CMP_CHK_FAIL_CAPTURE_EN to add first-mismatch capture outputs.
module comparator_checker
  import comparator_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 20,
  parameter int NUM_PASSES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             x_o,
  output logic             y_o,
  input  logic             z_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
`ifdef CMP_CHK_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic             fail_z
`endif
);

  localparam int PASS_W = (NUM_PASSES > 0) ? $clog2(NUM_PASSES + 1) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);

  state_e            state_q, state_d;
  logic [1:0]        vec_q, vec_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              pass_q, pass_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hold_clr_s, hold_en_s, expire_s, mismatch_s;
`ifdef CMP_CHK_FAIL_CAPTURE_EN
  logic              fail_valid_q, fail_valid_d;
  logic [1:0]        fail_vec_q, fail_vec_d;
  logic              fail_z_q, fail_z_d;
`endif

  assign hold_en_s  = (state_q == DRIVE);
  assign hold_clr_s = (state_q == IDLE) && start;
  assign mismatch_s = (z_i != expected_z(vec_q[1], vec_q[0]));

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (hold_clr_s),
    .en     (hold_en_s),
    .expire (expire_s)
  );

  // Sequencer next-state, vector/pass/error bookkeeping.
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    pass_cnt_d = pass_cnt_q;
    err_d      = err_q;
    pass_d     = pass_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef CMP_CHK_FAIL_CAPTURE_EN
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_z_d     = fail_z_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d    = DRIVE;
          busy_d     = 1'b1;
          vec_d      = 2'd0;
          pass_cnt_d = '0;
          err_d      = '0;
          pass_d     = 1'b0;
`ifdef CMP_CHK_FAIL_CAPTURE_EN
          fail_valid_d = 1'b0;
          fail_vec_d   = 2'd0;
          fail_z_d     = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        busy_d = 1'b1;
        if (expire_s) begin
          if (mismatch_s && (err_q != ERR_MAX)) begin
            err_d = err_q + ERR_W'(1);
          end else begin
            err_d = err_q;
          end
`ifdef CMP_CHK_FAIL_CAPTURE_EN
          if (mismatch_s && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
            fail_z_d     = z_i;
          end else begin
            fail_valid_d = fail_valid_q;
          end
`endif
          vec_d = vec_q + 2'd1;
          if (vec_q == 2'(NUM_VECTORS - 1)) begin
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
            if (pass_cnt_q == LAST_PASS) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_d == '0);
            end else begin
              state_d = DRIVE;
            end
          end else begin
            pass_cnt_d = pass_cnt_q;
          end
        end else begin
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        vec_d   = 2'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= 2'd0;
      pass_cnt_q <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CMP_CHK_FAIL_CAPTURE_EN
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 2'd0;
      fail_z_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      pass_cnt_q <= pass_cnt_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CMP_CHK_FAIL_CAPTURE_EN
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_z_q     <= fail_z_d;
`endif
    end
  end

  // vec_q wraps to 0 on the final sample, so x/y idle low outside DRIVE.
  assign x_o       = vec_q[1];
  assign y_o       = vec_q[0];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef CMP_CHK_FAIL_CAPTURE_EN
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_z     = fail_z_q;
`endif

endmodule

// File: tb/tb_comparator_checker.sv
// Directed bench for comparator_checker: three instances cover the default
// timing, a 100-pass saturating run and a 2-cycle hold with a registered z.
module tb_comparator_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_a_n;
  logic start_a, start_b, start_c;
  int   mode_a;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic x_a, y_a, z_a, busy_a, done_a, pass_a;
  logic [7:0] err_a;
  logic [1:0] vec_a;
  logic x_b, y_b, z_b, busy_b, done_b, pass_b;
  logic [7:0] err_b;
  logic [1:0] vec_b;
  logic x_c, y_c, z_c, busy_c, done_c, pass_c;
  logic [7:0] err_c;
  logic [1:0] vec_c;
`ifdef CMP_CHK_FAIL_CAPTURE_EN
  logic fv_a, fz_a, fv_b, fz_b, fv_c, fz_c;
  logic [1:0] fvec_a, fvec_b, fvec_c;
`endif

  // Comparator models: A selectable (xnor / stuck-0 / xor), B inverted, C registered xnor.
  always_comb begin
    case (mode_a)
      0:       z_a = ~(x_a ^ y_a);
      1:       z_a = 1'b0;
      default: z_a = x_a ^ y_a;
    endcase
  end
  assign z_b = x_b ^ y_b;
  always @(posedge clk) z_c <= ~(x_c ^ y_c);

  comparator_checker #(.HOLD_CYCLES(20), .NUM_PASSES(1)) u_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .x_o(x_a), .y_o(y_a), .z_i(z_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .vec_idx(vec_a)
`ifdef CMP_CHK_FAIL_CAPTURE_EN
    , .fail_valid(fv_a), .fail_vec(fvec_a), .fail_z(fz_a)
`endif
  );

  comparator_checker #(.HOLD_CYCLES(20), .NUM_PASSES(100)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x_o(x_b), .y_o(y_b), .z_i(z_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .vec_idx(vec_b)
`ifdef CMP_CHK_FAIL_CAPTURE_EN
    , .fail_valid(fv_b), .fail_vec(fvec_b), .fail_z(fz_b)
`endif
  );

  comparator_checker #(.HOLD_CYCLES(2), .NUM_PASSES(1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .x_o(x_c), .y_o(y_c), .z_i(z_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .vec_idx(vec_c)
`ifdef CMP_CHK_FAIL_CAPTURE_EN
    , .fail_valid(fv_c), .fail_vec(fvec_c), .fail_z(fz_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run of instance A; returns at the negedge after the done edge (E0+80).
  task automatic run_a(input bit mid_start);
    logic [1:0] v;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("a_err_cleared", {31'd0, (err_a == 8'd0)}, 32'd1);
    chk("a_pass_cleared", {31'd0, pass_a}, 32'd0);
    for (int m = 0; m < 80; m++) begin
      v = 2'(m / 20);
      chk("a_run_state", {26'd0, busy_a, done_a, vec_a, x_a, y_a}, {26'd0, 1'b1, 1'b0, v, v});
      start_a = (mid_start && (m == 45)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start_a = 1'b0;
    chk("a_done_state", {26'd0, busy_a, done_a, vec_a, x_a, y_a}, {26'd0, 6'b010000});
  endtask

  initial begin
    rst_n = 1'b0; rst_a_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a = 0;
    repeat (3) @(negedge clk);
    chk("reset_a", {20'd0, x_a, y_a, busy_a, done_a, pass_a, err_a, vec_a}, 32'd0);
    chk("reset_b", {20'd0, x_b, y_b, busy_b, done_b, pass_b, err_b, vec_b}, 32'd0);
    rst_n = 1'b1; rst_a_n = 1'b1;
    @(negedge clk);

    // Correct comparator: clean run, pass held in IDLE afterwards.
    mode_a = 0;
    run_a(1'b0);
    chk("t1_err", {24'd0, err_a}, 32'd0);
    chk("t1_pass", {31'd0, pass_a}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_idle", {29'd0, busy_a, done_a, pass_a}, 32'b001);

    // Stuck-at-0: mismatches on vectors 0 and 3.
    mode_a = 1;
    run_a(1'b0);
    chk("t2_err", {24'd0, err_a}, 32'd2);
    chk("t2_pass", {31'd0, pass_a}, 32'd0);
`ifdef CMP_CHK_FAIL_CAPTURE_EN
    chk("t2_fail_cap", {28'd0, fv_a, fvec_a, fz_a}, {28'd0, 1'b1, 2'd0, 1'b0});
`endif

    // Inverted comparator with a start pulse at vector 2 that must be ignored.
    mode_a = 2;
    run_a(1'b1);
    chk("t3_err", {24'd0, err_a}, 32'd4);
    chk("t3_pass", {31'd0, pass_a}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_single_done", {30'd0, busy_a, done_a}, 32'd0);
    end

    // Asynchronous reset during vector 1 of a stuck-at-0 run.
    mode_a = 1;
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (25) @(negedge clk);
    chk("t4_pre_vec", {30'd0, vec_a}, 32'd1);
    chk("t4_pre_err", {24'd0, err_a}, 32'd1);
    #2 rst_a_n = 1'b0;
    #1;
    chk("t4_reset_now", {20'd0, x_a, y_a, busy_a, done_a, pass_a, err_a, vec_a}, 32'd0);
`ifdef CMP_CHK_FAIL_CAPTURE_EN
    chk("t4_reset_fail", {28'd0, fv_a, fvec_a, fz_a}, 32'd0);
`endif
    @(negedge clk) rst_a_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_no_done", {30'd0, busy_a, done_a}, 32'd0);
    end
    run_a(1'b0);
    chk("t4_rerun_err", {24'd0, err_a}, 32'd2);

    // 100 passes, inverted comparator: saturation at 255 and 8000-cycle run.
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    chk("t5_busy", {31'd0, busy_b}, 32'd1);
    repeat (5099) @(negedge clk);
    chk("t5_err_254", {24'd0, err_b}, 32'd254);
    @(negedge clk);
    chk("t5_err_255", {24'd0, err_b}, 32'd255);
    repeat (2899) @(negedge clk);
    chk("t5_pre_done", {22'd0, busy_b, done_b, err_b}, {22'd0, 1'b1, 1'b0, 8'd255});
    @(negedge clk);
    chk("t5_done", {21'd0, busy_b, done_b, pass_b, err_b}, {21'd0, 1'b0, 1'b1, 1'b0, 8'd255});

    // Hold of 2 with a one-cycle-latency comparator.
    @(negedge clk) start_c = 1'b1;
    @(negedge clk) start_c = 1'b0;
    for (int m = 0; m < 8; m++) begin
      chk("t6_run", {28'd0, busy_c, done_c, vec_c}, {28'd0, 1'b1, 1'b0, 2'(m / 2)});
      @(negedge clk);
    end
    chk("t6_done", {21'd0, busy_c, done_c, pass_c, err_c}, {21'd0, 1'b0, 1'b1, 1'b1, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
